// File: rtl/self_com_slink_mon_pkg.sv
// Shared encodings for the SLINK link monitor: FSM states and error-cause codes,
// decoded identically by the diagnosis stage and register readback.
package self_com_slink_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_LINK_OK   = 2'd2,
    ST_LINK_ERR  = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_LINK_DOWN = 2'd1,
    CAUSE_TIMEOUT   = 2'd2,
    CAUSE_CRC       = 2'd3
  } err_cause_e;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/self_com_slink_wdog.sv
// Saturating frame watchdog: counts cycles since the last clear and flags a
// timeout while saturated, unless a clear arrives in that same cycle.
module self_com_slink_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic timeout
);

  localparam logic [15:0] SAT_VAL = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (cnt != SAT_VAL) cnt <= cnt + 16'd1;
  end

  // A frame in the saturation cycle wins over the timeout.
  assign timeout = (cnt == SAT_VAL) && !clr;

endmodule

// File: rtl/self_com_slink_mon.sv
// Receive-side SLINK link monitor with hysteresis. Optional error-entry counter
// enabled by defining SLINK_MON_ERR_CNT_EN (err_cnt reads 0 otherwise).
module self_com_slink_mon
  import self_com_slink_mon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1250,
  parameter int unsigned ERR_THR     = 3,
  parameter int unsigned RECOV_THR   = 4
) (
  input  logic        clk_12_5m,
  input  logic        rst_12_5m,
  input  logic        chn_enable,
  input  logic        link_up,
  input  logic        frame_vld,
  input  logic        frame_crc_ok,
  output logic        chn_slink_err,
  output logic [1:0]  err_cause,
  output logic [1:0]  mon_state,
  output logic [15:0] err_cnt
);

  localparam logic [3:0] ERR_T   = 4'(ERR_THR);
  localparam logic [3:0] RECOV_T = 4'(RECOV_THR);

  mon_state_e state, state_nxt;
  err_cause_e cause, cause_nxt, fault_cause;
  logic [3:0] bad_cnt, good_cnt, bad_nxt, good_nxt;
  logic       hold, timeout, fault, recover, err_nxt;

  self_com_slink_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk_12_5m),
    .rst_n   (rst_12_5m),
    .clr     (frame_vld || hold),
    .timeout (timeout)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hold     = (state == ST_IDLE) || !chn_enable;
    bad_nxt  = bad_cnt;
    good_nxt = good_cnt;
    if (frame_vld) begin
      if (frame_crc_ok) begin
        good_nxt = sat_inc4(good_cnt);
        bad_nxt  = '0;
      end else begin
        bad_nxt  = sat_inc4(bad_cnt);
        good_nxt = '0;
      end
    end
    if (timeout || !link_up) good_nxt = '0;
    if (hold) begin
      bad_nxt  = '0;
      good_nxt = '0;
    end

    // Thresholds are judged on the updated counts so the decision lands 1 clk after the frame.
    fault       = !link_up || timeout || (bad_nxt >= ERR_T);
    recover     = link_up && (good_nxt >= RECOV_T) && !fault;
    fault_cause = !link_up ? CAUSE_LINK_DOWN :
                  timeout  ? CAUSE_TIMEOUT   :
                  (bad_nxt >= ERR_T) ? CAUSE_CRC : CAUSE_NONE;

    state_nxt = state;
    cause_nxt = cause;
    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_WAIT_SYNC;
        cause_nxt = CAUSE_NONE;
      end
      ST_WAIT_SYNC: begin
        if (recover) begin
          state_nxt = ST_LINK_OK;
          cause_nxt = CAUSE_NONE;
        end else begin
          cause_nxt = fault_cause;
        end
      end
      ST_LINK_OK: begin
        cause_nxt = CAUSE_NONE;
        if (fault) begin
          state_nxt = ST_LINK_ERR;
          cause_nxt = fault_cause;
        end
      end
      ST_LINK_ERR: begin
        if (recover) begin
          state_nxt = ST_LINK_OK;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cause_nxt = CAUSE_NONE;
      end
    endcase
    if (!chn_enable) begin
      state_nxt = ST_IDLE;
      cause_nxt = CAUSE_NONE;
    end
    err_nxt = (state_nxt == ST_WAIT_SYNC) || (state_nxt == ST_LINK_ERR);
  end

  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      state         <= ST_IDLE;
      cause         <= CAUSE_NONE;
      bad_cnt       <= '0;
      good_cnt      <= '0;
      chn_slink_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      cause         <= cause_nxt;
      bad_cnt       <= bad_nxt;
      good_cnt      <= good_nxt;
      chn_slink_err <= err_nxt;
    end
  end

  assign err_cause = cause;
  assign mon_state = state;

`ifdef SLINK_MON_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Survives chn_enable=0; only reset clears the history.
  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      err_cnt_q <= '0;
    end else if ((state == ST_LINK_OK) && (state_nxt == ST_LINK_ERR) &&
                 (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_self_com_slink_mon.sv
// Self-checking bench for self_com_slink_mon: directed test-plan scenarios and
// randomized traffic, both compared every cycle against a behavioural model.
module tb_self_com_slink_mon;

  localparam int T = 16;
  localparam int E = 3;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, lu = 1'b0, fv = 1'b0, ok = 1'b0;
  logic        err;
  logic [1:0]  cause, state;
  logic [15:0] cnt;

  int checks   = 0;
  int failures = 0;

  // Model: link status by name-level rules (0 idle, 1 sync, 2 ok, 3 err).
  int m_state, m_cause, m_cnt;
  int since_frame, good_run, bad_run;

  self_com_slink_mon #(.TIMEOUT_CYC(T), .ERR_THR(E), .RECOV_THR(R)) dut (
    .clk_12_5m     (clk),
    .rst_12_5m     (rst_n),
    .chn_enable    (en),
    .link_up       (lu),
    .frame_vld     (fv),
    .frame_crc_ok  (ok),
    .chn_slink_err (err),
    .err_cause     (cause),
    .mon_state     (state),
    .err_cnt       (cnt)
  );

  always #40 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cause = 0; m_cnt = 0;
    since_frame = 0; good_run = 0; bad_run = 0;
  endtask

  task automatic model_step();
    bit timed_out, bad_lim, faulty, healthy;
    int why;
    if (!en) begin
      m_state = 0; m_cause = 0;
      since_frame = 0; good_run = 0; bad_run = 0;
      return;
    end
    if (m_state == 0) begin
      m_state = 1; m_cause = 0;
      return;
    end
    timed_out = !fv && (since_frame >= T - 1);
    if (fv) since_frame = 0;
    else if (since_frame < T - 1) since_frame++;
    if (fv && ok)  begin good_run = (good_run < 15) ? good_run + 1 : 15; bad_run = 0; end
    if (fv && !ok) begin bad_run = (bad_run < 15) ? bad_run + 1 : 15; good_run = 0; end
    if (timed_out || !lu) good_run = 0;
    bad_lim = (bad_run >= E);
    faulty  = !lu || timed_out || bad_lim;
    healthy = lu && (good_run >= R) && !faulty;
    why = !lu ? 1 : timed_out ? 2 : bad_lim ? 3 : 0;
    case (m_state)
      1: if (healthy) begin m_state = 2; m_cause = 0; end else m_cause = why;
      2: if (faulty) begin
           m_state = 3; m_cause = why;
`ifdef SLINK_MON_ERR_CNT_EN
           if (m_cnt < 16'hFFFF) m_cnt++;
`endif
         end
      3: if (healthy) begin m_state = 2; m_cause = 0; end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("err",   int'(err),   (m_state == 1 || m_state == 3) ? 1 : 0);
    check("cause", int'(cause), m_cause);
    check("cnt",   int'(cnt),   m_cnt);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cyc(input logic e, input logic l, input logic f, input logic k);
    en = e; lu = l; fv = f; ok = k;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    fv = 1'b0;
  endtask

  task automatic frame(input logic k);
    repeat (7) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, k);
  endtask

  task automatic async_reset();
    #20 rst_n = 1'b0;
    #1;
    check("rst_err",   int'(err),   0);
    check("rst_state", int'(state), 0);
    check("rst_cause", int'(cause), 0);
    check("rst_cnt",   int'(cnt),   0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rate, r;
    model_reset();
    #1;
    check("por_err",   int'(err),   0);
    check("por_state", int'(state), 0);
    check("por_cause", int'(cause), 0);
    check("por_cnt",   int'(cnt),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bring-up
    frame(1'b1);
    check("sync_state", int'(state), 1);
    check("sync_err",   int'(err),   1);
    repeat (3) frame(1'b1);
    check("up_state", int'(state), 2);
    check("up_err",   int'(err),   0);
    check("up_cause", int'(cause), 0);

    // Timeout
    repeat (15) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("to_pre_err", int'(err), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("to_err",   int'(err),   1);
    check("to_cause", int'(cause), 2);
`ifdef SLINK_MON_ERR_CNT_EN
    check("to_cnt", int'(cnt), 1);
`else
    check("to_cnt", int'(cnt), 0);
`endif
    repeat (4) frame(1'b1);
    check("to_recov", int'(state), 2);
    repeat (15) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("sat_frame_err", int'(err), 0);

    // CRC hysteresis
    frame(1'b0); frame(1'b0); frame(1'b1); frame(1'b0); frame(1'b0);
    check("crc_hold", int'(state), 2);
    frame(1'b0);
    check("crc_err",   int'(err),   1);
    check("crc_cause", int'(cause), 3);
    repeat (3) frame(1'b1);
    frame(1'b0);
    repeat (3) frame(1'b1);
    check("crc_not_yet", int'(state), 3);
    frame(1'b1);
    check("crc_recov", int'(state), 2);
    check("crc_recov_cause", int'(cause), 0);

    // Priority: link drop with 3rd bad frame
    frame(1'b0); frame(1'b0);
    repeat (7) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_cause", int'(cause), 1);

    // Disable in LINK_ERR
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("dis_state", int'(state), 0);
    check("dis_err",   int'(err),   0);
    check("dis_cause", int'(cause), 0);

    // Async reset mid-frame
    repeat (4) frame(1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    fv = 1'b1; ok = 1'b1;
    async_reset();
    fv = 1'b0;

    // Randomized traffic with varying frame density to provoke timeouts
    rate = 15;
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) begin
        r = $urandom_range(0, 3);
        rate = (r == 0) ? 0 : (r == 1) ? 5 : (r == 2) ? 15 : 40;
      end
      if ($urandom_range(0, 999) < 3) async_reset();
      else cyc($urandom_range(0, 199) != 0,
               $urandom_range(0, 99) > 2,
               $urandom_range(0, 99) < rate,
               $urandom_range(0, 99) < 75);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/self_com_slink_mon.md
Name: self_com_slink_mon

Overview:
- Receive-side SLINK link monitor: watches per-channel frame arrivals, CRC status and PHY lock, and produces the per-channel `chn_slink_err` flag.
- That flag is later gated by `chn_enable` and double-registered by the SLINK diagnosis stage.
- One instance per SLINK channel, in the clk_12_5m domain, between the SLINK frame receiver and the diagnosis stage.
- Provides hysteresis, so single glitches do not toggle the diagnosed error.

Parameters:
- TIMEOUT_CYC, 1250, cycles without a frame before a timeout is declared (100 us at 12.5 MHz); legal 2..65535.
- ERR_THR, 3, consecutive CRC-bad frames that declare a link error; legal 1..15.
- RECOV_THR, 4, consecutive CRC-good frames required to declare the link OK; legal 1..15.

Ports:
- clk_12_5m  in  1  sole clock, 12.5 MHz.
- rst_12_5m  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to clk_12_5m.
- chn_enable  in  1  channel configured/enabled; 0 forces the monitor idle.
- link_up  in  1  PHY/deserializer lock, level.
- frame_vld  in  1  one-cycle pulse at end of each received frame.
- frame_crc_ok  in  1  CRC result, qualified by frame_vld.
- chn_slink_err  out  1  registered channel error flag.
- err_cause  out  2  0 none, 1 link_down, 2 timeout, 3 crc.
- mon_state  out  2  FSM state, for debug readback.
- err_cnt  out  16  saturating count of LINK_OK->LINK_ERR entries (see Optional Feature).

Behaviour:
- Reset values: chn_slink_err=0, err_cause=0, mon_state=IDLE(0), err_cnt=0; all internal counters 0.
- Watchdog counter (16 bit):
  - Cleared on any frame_vld, regardless of CRC result.
  - Otherwise increments.
  - Saturates at TIMEOUT_CYC-1; the timeout event is asserted while the counter is saturated.
  - frame_vld in the same cycle as saturation: the frame wins, the counter clears and no timeout is raised.
- bad_cnt / good_cnt (4 bit, saturating at 15):
  - frame_vld with crc_ok=0: increments bad_cnt and clears good_cnt.
  - frame_vld with crc_ok=1: increments good_cnt and clears bad_cnt.
  - A timeout or link_up=0 clears good_cnt.
- FSM states, encoded IDLE=0, WAIT_SYNC=1, LINK_OK=2, LINK_ERR=3:
  - IDLE: all counters are held at 0 and chn_slink_err=0. When chn_enable=1, go to WAIT_SYNC.
  - WAIT_SYNC: chn_slink_err=1. Go to LINK_OK when good_cnt reaches RECOV_THR and link_up=1. err_cause tracks the current fault, or 0 if there is none.
  - LINK_OK: chn_slink_err=0, err_cause=0. Go to LINK_ERR on any fault: link_up=0, timeout, or bad_cnt reaching ERR_THR.
  - LINK_ERR: chn_slink_err=1. Go to LINK_OK when good_cnt reaches RECOV_THR and link_up=1.
  - chn_enable=0 in any state: IDLE next cycle; counters and err_cause are cleared.
- err_cause rules:
  - Latched on entry to LINK_ERR with priority link_down > timeout > crc.
  - Held while in LINK_ERR.
  - Cleared on entry to LINK_OK.
- Latency: chn_slink_err and err_cause change exactly 1 clk after the cycle in which the transition condition is true; all outputs are registered.
- Simultaneous events:
  - A recovery condition and a fault in the same cycle: the fault wins.
  - Asynchronous reset mid-frame returns the monitor to IDLE with no residual counts.

Optional Feature:
- Macro: SLINK_MON_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on every LINK_OK->LINK_ERR transition and saturates at 16'hFFFF. It is cleared only by reset; chn_enable=0 does not clear it.
- Undefined: err_cnt is tied to 16'h0000 and no counter flops are instantiated.

Decomposition:
- Shared package/defines file: FSM state encodings (IDLE/WAIT_SYNC/LINK_OK/LINK_ERR) and err_cause codes. The SLINK diagnosis stage and register readback decode the same values.
- Sub-module: self_com_slink_wdog, the parameterised saturating watchdog counter with clear and timeout output.
- All remaining logic stays in the top level.

Test Plan (bench overrides TIMEOUT_CYC=16, ERR_THR=3, RECOV_THR=4):
- Bring-up: release reset, chn_enable=1, link_up=1, 4 good frames every 8 cycles -> WAIT_SYNC then LINK_OK; chn_slink_err falls 1 clk after the 4th frame_vld; err_cause=0.
- Timeout: in LINK_OK, stop frames -> after 15 idle cycles the timeout asserts; next clk chn_slink_err=1, err_cause=2, err_cnt=1. A frame_vld arriving in the saturation cycle prevents the error.
- CRC hysteresis: in LINK_OK, send bad, bad, good, bad, bad -> no error. A 3rd consecutive bad frame -> chn_slink_err=1, err_cause=3. Then 3 good + 1 bad + 4 good -> LINK_OK only after the final 4th good frame.
- Priority: drop link_up in the same cycle as a 3rd bad frame -> err_cause=1.
- Disable/reset: assert chn_enable=0 in LINK_ERR -> next clk IDLE, chn_slink_err=0, err_cause=0. Async reset low mid-frame -> outputs clear immediately without a clock edge.
- Macro off: repeat the timeout test -> err_cnt stays 0.
